// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: the response-owner encoding and default widths.
package mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared single-port RAM port.
// Handshake: a requester raises req and holds addr/we/be/wdata stable until the cycle its gnt is 1.
// The response (valid + rdata) arrives exactly one cycle after gnt. There is no backpressure on responses.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_pkg::DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared synchronous-read instruction/data RAM between fetch and load/store,
// alternating under contention and steering the one-cycle-late read data back to the owner.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 stall_if,
  output logic [CNT_W-1:0]     conflict_cnt,
  output owner_e               dbg_owner,
  output logic                 dbg_prio_if
);

  localparam int BE_W = DATA_W / 8;

  logic   if_win;
  logic   d_win;
  logic   both_req;
  logic   prio_if;
  logic   prio_if_d;
  owner_e owner_q;
  owner_e owner_d;
  logic   store_q;
  logic   store_d;
  logic   resp_if;
  logic   resp_d;

  logic [ADDR_W-3:0] if_waddr;
  logic [ADDR_W-3:0] d_waddr;
  logic              unused_addr_lsbs;

  assign if_waddr         = bus.if_addr[ADDR_W-1:2];
  assign d_waddr          = bus.d_addr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};
  assign both_req         = bus.if_req & bus.d_req;

  // Grant: a lone requester always wins; under contention prio_if picks the side.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!rst) begin
      if (both_req) begin
        if_win = prio_if;
        d_win  = ~prio_if;
      end else begin
        if_win = bus.if_req;
        d_win  = bus.d_req;
      end
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign stall_if      = ~rst & bus.if_req & ~if_win;
  assign bus.mem_en    = if_win | d_win;
  assign bus.mem_addr  = d_win ? d_waddr : if_waddr;
  assign bus.mem_we    = (d_win && bus.d_we) ? bus.d_be : BE_W'(0);
  assign bus.mem_wdata = bus.d_wdata;

  // Owner / priority next-state.
  always_comb begin
    owner_d   = OWN_NONE;
    store_d   = 1'b0;
    prio_if_d = prio_if;
    if (if_win) begin
      owner_d   = OWN_IF;
      prio_if_d = 1'b0;
    end else if (d_win) begin
      owner_d = OWN_DATA;
      store_d = bus.d_we;
      if (bus.if_req) prio_if_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      store_q <= 1'b0;
      prio_if <= 1'b0;
    end else begin
      owner_q <= owner_d;
      store_q <= store_d;
      prio_if <= prio_if_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (both_req && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Responses are masked during reset so an access granted just before it is dropped.
  assign resp_if      = ~rst & (owner_q == OWN_IF);
  assign resp_d       = ~rst & (owner_q == OWN_DATA);
  assign bus.if_valid = resp_if;
  assign bus.if_rdata = resp_if ? bus.mem_rdata : '0;
  assign bus.d_valid  = resp_d;
  assign bus.d_rdata  = (resp_d && !store_q) ? bus.mem_rdata : '0;

  assign dbg_owner   = owner_q;
  assign dbg_prio_if = prio_if;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a RAM model behind the memory port and a response scoreboard.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  logic        stall_if;
  logic [15:0] conflict_cnt;
  owner_e      dbg_owner;
  logic        dbg_prio_if;
  logic        stall_if4;
  logic [3:0]  conflict_cnt4;
  owner_e      dbg_owner4;
  logic        dbg_prio_if4;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_if(stall_if),
    .conflict_cnt(conflict_cnt), .dbg_owner(dbg_owner), .dbg_prio_if(dbg_prio_if)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .stall_if(stall_if4),
    .conflict_cnt(conflict_cnt4), .dbg_owner(dbg_owner4), .dbg_prio_if(dbg_prio_if4)
  );

  // Second instance sees the same request stream; only its counter is of interest.
  assign bus4.if_req    = bus.if_req;
  assign bus4.if_addr   = bus.if_addr;
  assign bus4.d_req     = bus.d_req;
  assign bus4.d_we      = bus.d_we;
  assign bus4.d_be      = bus.d_be;
  assign bus4.d_addr    = bus.d_addr;
  assign bus4.d_wdata   = bus.d_wdata;
  assign bus4.mem_rdata = bus.mem_rdata;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0050_0093;
    if (i == 8) return 32'h1122_3344;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Synchronous-read RAM behind the memory port, preloaded while reset is high.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  // Scoreboard: one entry {owner, rdata} per cycle, popped in the response cycle.
  logic [33:0] exp_q[$];
  logic [31:0] ref_ram [0:255];
  bit          p;
  int          cnt;
  int          cnt4;
  int          tests;
  int          fails;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dd);
    bit          gi;
    bit          gd;
    logic [33:0] e;
    logic [1:0]  eo;
    logic [31:0] ed;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_be    = dbe;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    gi = ir && (!dr || p);
    gd = dr && !gi;
    @(negedge clk);
    check("if_gnt", bus.if_gnt, gi);
    check("d_gnt", bus.d_gnt, gd);
    check("stall_if", stall_if, ir && !gi);
    check("mem_en", bus.mem_en, gi || gd);
    check("mem_we", bus.mem_we, (gd && dwe) ? dbe : 4'b0);
    if (gi || gd) check("mem_addr", bus.mem_addr, gd ? da[31:2] : ia[31:2]);
    if (gd && dwe) check("mem_wdata", bus.mem_wdata, dd);
    check("conflict_cnt", conflict_cnt, cnt);
    check("conflict_cnt4", conflict_cnt4, cnt4);
    check("prio_if", dbg_prio_if, p);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e  = exp_q.pop_front();
      eo = e[33:32];
      ed = e[31:0];
      check("if_valid", bus.if_valid, eo == OWN_IF);
      check("if_rdata", bus.if_rdata, (eo == OWN_IF) ? ed : 32'h0);
      check("d_valid", bus.d_valid, eo == OWN_DATA);
      check("d_rdata", bus.d_rdata, (eo == OWN_DATA) ? ed : 32'h0);
    end
    if (gi) begin
      exp_q.push_back({OWN_IF, ref_ram[ia[9:2]]});
      p = 1'b0;
    end else if (gd) begin
      exp_q.push_back({OWN_DATA, dwe ? 32'h0 : ref_ram[da[9:2]]});
      if (dwe)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_ram[da[9:2]][8*b +: 8] = dd[8*b +: 8];
      if (ir) p = 1'b1;
    end else begin
      exp_q.push_back({OWN_NONE, 32'h0});
    end
    if (ir && dr) begin
      if (cnt < 65535) cnt++;
      if (cnt4 < 15) cnt4++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a);
    tick(1'b1, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    tick(1'b0, 32'h0, 1'b1, 1'b1, be, a, d);
  endtask

  task automatic both_load(input logic [31:0] ia, input logic [31:0] da);
    tick(1'b1, ia, 1'b1, 1'b0, 4'h0, da, 32'h0);
  endtask

  // Reset with both requests raised: grants must stay low and any pending response is dropped.
  task automatic do_reset();
    rst         = 1'b1;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    @(negedge clk);
    check("rst_if_gnt", bus.if_gnt, 1'b0);
    check("rst_d_gnt", bus.d_gnt, 1'b0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_stall_if", stall_if, 1'b0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_d_valid", bus.d_valid, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    check("post_rst_owner", dbg_owner, OWN_NONE);
    check("post_rst_prio", dbg_prio_if, 1'b0);
    check("post_rst_cnt", conflict_cnt, 16'd0);
    check("post_rst_cnt4", conflict_cnt4, 4'd0);
    check("post_rst_if_valid", bus.if_valid, 1'b0);
    check("post_rst_d_valid", bus.d_valid, 1'b0);
    check("post_rst_if_rdata", bus.if_rdata, 32'h0);
    check("post_rst_d_rdata", bus.d_rdata, 32'h0);
    p    = 1'b0;
    cnt  = 0;
    cnt4 = 0;
    for (int i = 0; i < 256; i++) ref_ram[i] = init_word(i);
    exp_q.push_back({OWN_NONE, 32'h0});
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'h0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    do_reset();

    // Fetch only
    fetch(32'h0000_0010);
    idle();

    // Contention: D, I, D, I with loads
    for (int i = 0; i < 4; i++) both_load(32'h0000_0014, 32'h0000_0040);
    idle();

    // Store then load to the same word; address LSBs are ignored on the load
    store(32'h0000_0020, 4'b0011, 32'hAABB_CCDD);
    load(32'h0000_0023);
    idle();

    // Back-to-back fetches
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    idle();

    // Mixed traffic: fetch response alongside a store grant, then randomized singles
    fetch(32'h0000_000C);
    store(32'h0000_0050, 4'b1100, 32'h1234_5678);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1, 0) == 1)
        fetch(32'($urandom_range(63, 0)) << 2);
      else
        load(32'($urandom_range(63, 0)) << 2);
    end
    load(32'h0000_0050);
    idle();

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) both_load(32'h0000_0018, 32'h0000_0044);
    idle();
    check("cnt4_saturated", conflict_cnt4, 4'd15);
    check("cnt16_after_sat", conflict_cnt, 16'd24);

    // Reset in the cycle after a load grant
    load(32'h0000_0030);
    do_reset();
    fetch(32'h0000_0010);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
